// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide unit for the execute stage. It uses shift-add
// multiply and restoring divide on operand magnitudes, then applies a sign fix-up cycle.
module muldiv_seq #(
  parameter int         N         = 32,
  parameter logic [4:0] ALUOP_MUL = 5'd12,
  parameter logic [4:0] ALUOP_DIV = 5'd13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   aluop,
  input  logic [N-1:0] s,
  input  logic [N-1:0] t,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         overflow
);

  localparam int            CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           is_div_q, is_div_d;
  logic           sign_s_q, sign_s_d;
  logic           sign_t_q, sign_t_d;
  logic           min_ovf_q, min_ovf_d;
  logic [2*N-1:0] opa_q, opa_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   hi_q, hi_d;

  logic [N-1:0]   abs_s, abs_t, quo_fix, rem_fix;
  logic [N:0]     rem_sh, div_diff;
  logic [2*N-1:0] prod_fix;
  logic           accept, neg;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    sign_s_d  = sign_s_q;
    sign_t_d  = sign_t_q;
    min_ovf_d = min_ovf_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ovf_d     = ovf_q;

    abs_s    = s[N-1] ? ({N{1'b0}} - s) : s;
    abs_t    = t[N-1] ? ({N{1'b0}} - t) : t;
    neg      = sign_s_q ^ sign_t_q;
    // The next dividend bit always sits at opa_q[N-1] because the dividend shifts left each step.
    rem_sh   = {rem_q, opa_q[N-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    prod_fix = neg ? ({(2*N){1'b0}} - acc_q) : acc_q;
    quo_fix  = neg ? ({N{1'b0}} - quo_q) : quo_q;
    rem_fix  = sign_s_q ? ({N{1'b0}} - rem_q) : rem_q;
    accept   = start && !flush && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_div_d  = (aluop == ALUOP_DIV);
          sign_s_d  = s[N-1];
          sign_t_d  = t[N-1];
          min_ovf_d = (s == MIN_VAL) && (t == '1);
          opa_d     = {{N{1'b0}}, abs_s};
          opb_d     = abs_t;
          acc_d     = '0;
          rem_d     = '0;
          quo_d     = '0;
          count_d   = '0;
          // Divide-by-zero completes immediately and never enters the iteration loop.
          if ((aluop == ALUOP_DIV) && (t == '0)) begin
            done_d = 1'b1;
            lo_d   = '0;
            hi_d   = s;
            ovf_d  = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + CW'(1);
          if (count_q == LAST) state_d = FIX;
          if (is_div_q) begin
            rem_d = div_diff[N] ? rem_sh[N-1:0] : div_diff[N-1:0];
            quo_d = {quo_q[N-2:0], ~div_diff[N]};
            opa_d = opa_q << 1;
          end else begin
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q && min_ovf_q) begin
            lo_d  = MIN_VAL;
            hi_d  = '0;
            ovf_d = 1'b1;
          end else if (is_div_q) begin
            lo_d  = quo_fix;
            hi_d  = rem_fix;
            ovf_d = 1'b0;
          end else begin
            lo_d  = prod_fix[N-1:0];
            hi_d  = prod_fix[2*N-1:N];
            ovf_d = (prod_fix[2*N-1:N] != {N{prod_fix[N-1]}});
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      sign_s_q  <= 1'b0;
      sign_t_q  <= 1'b0;
      min_ovf_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      sign_s_q  <= sign_s_d;
      sign_t_q  <= sign_t_d;
      min_ovf_q <= min_ovf_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq. An arithmetic reference model predicts each
// completion, and a monitor pops the predictions whenever done is seen.
module tb_muldiv_seq;

  localparam int         N      = 32;
  localparam logic [4:0] OP_MUL = 5'd12;
  localparam logic [4:0] OP_DIV = 5'd13;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [N-1:0] MIN_VAL = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [4:0]   aluop;
  logic [N-1:0] s, t;
  logic         busy, done, overflow;
  logic [N-1:0] result_lo, result_hi;

  muldiv_seq #(.N(N), .ALUOP_MUL(OP_MUL), .ALUOP_DIV(OP_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .s(s), .t(t),
    .flush(flush), .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic         ovf;
    int           done_cyc;
    int           busy_cycles;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [N-1:0] last_lo = '0;
  logic [N-1:0] last_hi = '0;
  logic         last_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against a model-derived value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain signed arithmetic with truncating division.
  function automatic exp_t model(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    longint maxv = 2147483647;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.busy_cycles = N + 1;
    e.done_cyc    = N + 2;
    if (op == OP_MUL) begin
      p     = sa * sb;
      e.lo  = p[31:0];
      e.hi  = p[63:32];
      e.ovf = (p > maxv) || (p < -maxv - 1);
    end else if (b == 0) begin
      e.lo = '0; e.hi = a; e.ovf = 1'b1;
      e.busy_cycles = 0;
      e.done_cyc    = 1;
    end else if (a == MIN_VAL && b == '1) begin
      e.lo = MIN_VAL; e.hi = '0; e.ovf = 1'b1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      e.lo  = q[31:0];
      e.hi  = r[31:0];
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Drive start for one cycle; push the prediction when a completion is expected.
  task automatic applyStimulus(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                               input bit expect_done);
    exp_t e;
    aluop = op; s = a; t = b; start = 1'b1;
    if (expect_done) begin
      e = model(op, a, b);
      e.done_cyc = e.done_cyc + cyc;
      sb_q.push_back(e);
      last_lo = e.lo; last_hi = e.hi; last_ovf = e.ovf;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, required done", n);
      sb_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [N-1:0] randOperand();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = '1;
      3: v = MIN_VAL;
      4: v = N'($urandom_range(0, 40)) - N'(20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every done must match the oldest outstanding prediction.
  always begin
    @(posedge clk); #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_done: got done=1, required no done");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("result_lo", 64'(result_lo), 64'(mon_e.lo));
        checkOutput("result_hi", 64'(result_hi), 64'(mon_e.hi));
        checkOutput("overflow", 64'(overflow), 64'(mon_e.ovf));
        checkOutput("latency", 64'(cyc), 64'(mon_e.done_cyc));
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(mon_e.busy_cycles));
      end
    end
    if (busy) busy_cnt++;
    else busy_cnt = 0;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; aluop = '0; s = '0; t = '0;
    idle(3);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_lo", 64'(result_lo), 64'd0);
    checkOutput("reset_hi", 64'(result_hi), 64'd0);
    checkOutput("reset_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    idle(1);

    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 1); waitDone(); idle(1);
    applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1); waitDone();
    applyStimulus(OP_MUL, MIN_VAL, 32'hFFFF_FFFF, 1); waitDone(); idle(1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1); waitDone();
    applyStimulus(OP_DIV, MIN_VAL, 32'hFFFF_FFFF, 1); waitDone(); idle(1);
    applyStimulus(OP_DIV, 32'd5, 32'd0, 1); waitDone(); idle(1);

    applyStimulus(OP_ADD, 32'd1, 32'd2, 0);
    checkOutput("bad_op_busy", 64'(busy), 64'd0);
    idle(40);
    checkOutput("bad_op_lo", 64'(result_lo), 64'(last_lo));
    checkOutput("bad_op_hi", 64'(result_hi), 64'(last_hi));
    checkOutput("bad_op_ovf", 64'(overflow), 64'(last_ovf));

    applyStimulus(OP_MUL, 32'd3, 32'd4, 1);
    idle(3);
    applyStimulus(OP_MUL, 32'd9, 32'd4, 0);
    waitDone();
    applyStimulus(OP_MUL, 32'd2, 32'd5, 1); waitDone(); idle(1);

    applyStimulus(OP_DIV, 32'd100, 32'd7, 0);
    idle(8);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    idle(40);
    checkOutput("flush_lo", 64'(result_lo), 64'(last_lo));
    checkOutput("flush_hi", 64'(result_hi), 64'(last_hi));
    checkOutput("flush_ovf", 64'(overflow), 64'(last_ovf));

    aluop = OP_MUL; s = 32'd6; t = 32'd6; start = 1'b1; flush = 1'b1;
    idle(1);
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_beats_start", 64'(busy), 64'd0);
    idle(40);

    applyStimulus(OP_DIV, 32'd100, 32'd7, 0);
    idle(18);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    last_lo = '0; last_hi = '0; last_ovf = 1'b0;
    checkOutput("midop_rst_busy", 64'(busy), 64'd0);
    checkOutput("midop_rst_done", 64'(done), 64'd0);
    checkOutput("midop_rst_lo", 64'(result_lo), 64'd0);
    checkOutput("midop_rst_hi", 64'(result_hi), 64'd0);
    checkOutput("midop_rst_ovf", 64'(overflow), 64'd0);
    idle(40);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL, randOperand(), randOperand(), 1);
      waitDone();
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(3);
    checkOutput("pending_predictions", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multi-cycle multiply/divide sequencer that takes ALUOP_MUL and ALUOP_DIV work off the single-cycle ALU. It sits beside the ALU in the execute stage. The pipeline controller issues an operation with a start pulse, holds while busy, and collects a 2N-bit product or a quotient/remainder pair on done. The algorithms are shift-add multiply and restoring divide on magnitudes, followed by a sign-fix step.

Parameters:
N, 32, operand/result width; the iteration count equals N.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when the unit is not busy
aluop  input  5  operation code from defines.v; only `ALUOP_MUL and `ALUOP_DIV are accepted
s  input  N  operand 1 (multiplicand/dividend), two's complement
t  input  N  operand 2 (multiplier/divisor), two's complement
flush  input  1  synchronous abort of an in-flight operation
busy  output  1  high while in CALC or FIX
done  output  1  one-cycle pulse; results valid from this cycle onward
result_lo  output  N  MUL: product[N-1:0]; DIV: quotient
result_hi  output  N  MUL: product[2N-1:N]; DIV: remainder
overflow  output  1  MUL: product does not fit in N bits; DIV: divide-by-zero or MIN/-1

Behaviour:
- Reset: state=IDLE. busy, done and overflow are 0; result_lo and result_hi are 0; the iteration counter is 0. rst overrides start and flush and aborts any operation mid-flight, with no done pulse.
- States: IDLE, CALC, FIX. done is a registered pulse, not a separate state.
- Accept: on an edge with start=1, state IDLE, and aluop equal to MUL or DIV, capture the signs of s and t, load |s| and |t|, and clear the counter. Results are not cleared on accept.
- start with any other aluop: ignored; the unit stays IDLE, busy stays 0, and no done is produced.
- start while busy: ignored; operands are not re-sampled.
- DIV with t==0: from IDLE go to IDLE on the next edge with done=1, result_lo=0, result_hi=s, overflow=1. Latency is 1 edge; CALC is not entered.
- CALC: one iteration per edge, N edges in total; the counter runs 0..N-1 and moves to FIX after count==N-1.
  - MUL: 2N-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - DIV: restoring; shift the remainder left, subtract the divisor, restore if negative, shift the quotient bit in.
- FIX (1 edge):
  - MUL: negate the 2N-bit product if sign(s)!=sign(t). overflow = (result_hi != {N{result_lo[N-1]}}).
  - DIV: negate the quotient if sign(s)!=sign(t); the remainder takes the sign of s (truncation toward zero).
  - DIV s==MIN, t==-1: result_lo=MIN, result_hi=0, overflow=1.
  - Write result_lo, result_hi and overflow, set done=1 for one cycle, and return to IDLE.
- Latency (normal): start accepted at edge E0 → done high in the cycle after edge E0+N+1, i.e. N+2 cycles after the start cycle (34 for N=32).
- busy is high in the cycles following E0 through the FIX cycle. busy=0 in the done cycle, so back-to-back start in the done cycle is accepted.
- Outputs hold their values until the next completed operation or reset. Intermediate CALC values never appear on result_lo/result_hi.
- flush: on an edge with flush=1 and state CALC/FIX, go to IDLE with busy=0 and no done; result/overflow keep their previous values. A flush in IDLE has no effect. If flush and start are both high in IDLE, flush wins (start is dropped).
- Width rule: all arithmetic is internal at N+1 bits (divide) / 2N bits (multiply); no truncation before FIX.

Test Plan:
- MUL s=7, t=0xFFFFFFFD (-3), start one cycle → busy 1 for 33 cycles; done at cycle 34; result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF, overflow=0.
- MUL s=0x00010000, t=0x00010000 → result_lo=0x00000000, result_hi=0x00000001, overflow=1. Then MUL s=0x80000000, t=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, overflow=1.
- DIV s=0xFFFFFFF9 (-7), t=2 → result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1), overflow=0. Then DIV s=0x80000000, t=0xFFFFFFFF → lo=0x80000000, hi=0, overflow=1.
- DIV s=5, t=0 → done one cycle after start, busy never 1, lo=0, hi=5, overflow=1. Then start with aluop=`ALUOP_ADD → no busy, no done, outputs unchanged.
- MUL 3×4 in progress: re-assert start with s=9 at cycle 5 → ignored, final lo=12. Assert start with MUL 2×5 in the done cycle → accepted, lo=10 after 34 more cycles.
- Start DIV 100/7, then flush at cycle 10 → busy drops next cycle, no done, outputs keep prior values. Repeat the operation with rst at cycle 20 → all outputs 0, state IDLE, no done.
